// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// dmem_ctrl : data-memory controller with fixed latency, sub-word store RMW
//             and misaligned-store rejection, in front of a 64-bit SRAM.
// Revision  : 1.0
// ============================================================================
module dmem_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] data_addr_in,
  input  logic              rdata_en_in,
  input  logic              wdata_en_in,
  input  logic [63:0]       wdata_in,
  input  logic [1:0]        wlen_in,
  output logic              wdata_ready_out,
  output logic [63:0]       rdata_out,
  output logic              rdata_valid_out,
  output logic              misalign_err_out,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-4:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata
);

  localparam logic [2:0] c_lat = 3'(MEM_LAT);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ISSUE, S_RD_WAIT, S_RMW_ISSUE,
    S_RMW_WAIT, S_WR_ISSUE, S_RESP, S_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [1:0]        wlen_q, wlen_d;
  logic              is_wr_q, is_wr_d;
  logic              mis_q, mis_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [63:0]       rdata_q, rdata_d;

  logic              w_mis;
  logic [63:0]       w_size_mask;
  logic [5:0]        w_shift;
  logic [63:0]       w_merged;

  always_comb begin
    w_mis = 1'b0;
    case (wlen_in)
      2'd1:    w_mis = data_addr_in[0];
      2'd2:    w_mis = |data_addr_in[1:0];
      2'd3:    w_mis = |data_addr_in[2:0];
      default: w_mis = 1'b0;
    endcase
  end

  // Store lanes are placed at the byte offset inside the doubleword; data
  // bits above the store size are discarded.
  always_comb begin
    w_size_mask = '1;
    case (wlen_q)
      2'd0:    w_size_mask = 64'h0000_0000_0000_00FF;
      2'd1:    w_size_mask = 64'h0000_0000_0000_FFFF;
      2'd2:    w_size_mask = 64'h0000_0000_FFFF_FFFF;
      default: w_size_mask = '1;
    endcase
    w_shift  = {addr_q[2:0], 3'b000};
    w_merged = (mem_rdata & ~(w_size_mask << w_shift)) |
               ((wdata_q & w_size_mask) << w_shift);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wlen_d  = wlen_q;
    is_wr_d = is_wr_q;
    mis_d   = mis_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (wdata_en_in) begin
          addr_d  = data_addr_in;
          wdata_d = wdata_in;
          wlen_d  = wlen_in;
          is_wr_d = 1'b1;
          mis_d   = w_mis;
          if (w_mis)               state_d = S_RESP;
          else if (wlen_in == 2'd3) state_d = S_WR_ISSUE;
          else                     state_d = S_RMW_ISSUE;
        end else if (rdata_en_in) begin
          addr_d  = data_addr_in;
          is_wr_d = 1'b0;
          mis_d   = 1'b0;
          state_d = S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: begin
        cnt_d   = 3'd1;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (cnt_q == c_lat) begin
          rdata_d = mem_rdata;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_RMW_ISSUE: begin
        cnt_d   = 3'd1;
        state_d = S_RMW_WAIT;
      end
      S_RMW_WAIT: begin
        if (cnt_q == c_lat) begin
          wdata_d = w_merged;
          state_d = S_WR_ISSUE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_WR_ISSUE: state_d = S_RESP;
      S_RESP:     state_d = S_HOLD;
      S_HOLD:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wlen_q  <= '0;
      is_wr_q <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wlen_q  <= wlen_d;
      is_wr_q <= is_wr_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // SRAM strobes are decoded from state so reset kills a pending write at once.
  assign mem_ce           = (state_q == S_RD_ISSUE) || (state_q == S_RMW_ISSUE) ||
                            (state_q == S_WR_ISSUE);
  assign mem_we           = (state_q == S_WR_ISSUE);
  assign mem_addr         = mem_ce ? addr_q[ADDR_W-1:3] : '0;
  assign mem_wdata        = mem_we ? wdata_q : '0;
  assign wdata_ready_out  = (state_q == S_RESP) && is_wr_q;
  assign rdata_valid_out  = (state_q == S_RESP) && !is_wr_q;
  assign misalign_err_out = (state_q == S_RESP) && is_wr_q && mis_q;
  assign rdata_out        = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// tb_dmem_ctrl : scoreboard bench for dmem_ctrl (MEM_LAT=1 main instance,
//                MEM_LAT=3 instance for back-to-back read hold-off).
// Revision     : 1.0
// ============================================================================
module tb_dmem_ctrl;

  localparam int LAT  = 1;
  localparam int LAT2 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn = 1'b0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // main instance
  logic [31:0] d_addr = '0;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [63:0] wdata = '0;
  logic [1:0]  wlen = '0;
  logic        wready, rvalid, mis;
  logic [63:0] rdata;
  logic        m_ce, m_we;
  logic [28:0] m_addr;
  logic [63:0] m_wdata, m_rdata;

  dmem_ctrl #(.ADDR_W(32), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rstn(rstn), .data_addr_in(d_addr), .rdata_en_in(rd_en),
    .wdata_en_in(wr_en), .wdata_in(wdata), .wlen_in(wlen),
    .wdata_ready_out(wready), .rdata_out(rdata), .rdata_valid_out(rvalid),
    .misalign_err_out(mis), .mem_ce(m_ce), .mem_we(m_we), .mem_addr(m_addr),
    .mem_wdata(m_wdata), .mem_rdata(m_rdata)
  );

  // second instance, long latency, reads only
  logic [31:0] d_addr2 = '0;
  logic        rd_en2 = 1'b0, wr_en2 = 1'b0;
  logic [63:0] wdata2 = '0;
  logic [1:0]  wlen2 = '0;
  logic        wready2, rvalid2, mis2;
  logic [63:0] rdata2;
  logic        m2_ce, m2_we;
  logic [28:0] m2_addr;
  logic [63:0] m2_wdata, m2_rdata;

  dmem_ctrl #(.ADDR_W(32), .MEM_LAT(LAT2)) u_dut2 (
    .clk(clk), .rstn(rstn), .data_addr_in(d_addr2), .rdata_en_in(rd_en2),
    .wdata_en_in(wr_en2), .wdata_in(wdata2), .wlen_in(wlen2),
    .wdata_ready_out(wready2), .rdata_out(rdata2), .rdata_valid_out(rvalid2),
    .misalign_err_out(mis2), .mem_ce(m2_ce), .mem_we(m2_we), .mem_addr(m2_addr),
    .mem_wdata(m2_wdata), .mem_rdata(m2_rdata)
  );

  // SRAM models; read data appears LAT cycles after issue, poison otherwise
  logic [63:0] mem1 [16];
  logic [63:0] mem2 [16];
  logic [63:0] pipe1 [LAT];
  logic [63:0] pipe2 [LAT2];
  logic        pl1_en = 1'b0, pl2_en = 1'b0;
  logic [3:0]  pl_idx = '0;
  logic [63:0] pl_val = '0;
  int          ce_cnt = 0, we_cnt = 0;

  always @(posedge clk) begin
    if (pl1_en) mem1[pl_idx] <= pl_val;
    if (m_ce && m_we) mem1[m_addr[3:0]] <= m_wdata;
    pipe1[0] <= (m_ce && !m_we) ? mem1[m_addr[3:0]] : 64'hBADC_0FFE_E0DD_F00D;
    for (int i = 1; i < LAT; i++) pipe1[i] <= pipe1[i-1];
    if (m_ce) ce_cnt <= ce_cnt + 1;
    if (m_ce && m_we) we_cnt <= we_cnt + 1;
  end
  assign m_rdata = pipe1[LAT-1];

  always @(posedge clk) begin
    if (pl2_en) mem2[pl_idx] <= pl_val;
    if (m2_ce && m2_we) mem2[m2_addr[3:0]] <= m2_wdata;
    pipe2[0] <= (m2_ce && !m2_we) ? mem2[m2_addr[3:0]] : 64'hBADC_0FFE_E0DD_F00D;
    for (int i = 1; i < LAT2; i++) pipe2[i] <= pipe2[i-1];
  end
  assign m2_rdata = pipe2[LAT2-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboards
  typedef struct {
    bit          wr;
    bit          mis;
    logic [63:0] rd;
    int          at;
  } exp_t;
  exp_t        q1[$];
  int          q2[$];
  logic [63:0] hold_rd = '0;

  always @(negedge clk) begin
    exp_t e;
    if (rstn && (wready || rvalid)) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_pulse: got wready=%0b rvalid=%0b expected none (cycle %0d)",
                 wready, rvalid, cyc);
      end else begin
        e = q1.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.at));
        chk("wready", 64'(wready), 64'(e.wr));
        chk("rvalid", 64'(rvalid), 64'(!e.wr));
        chk("misalign", 64'(mis), 64'(e.mis));
        chk("rdata_out", rdata, e.rd);
      end
    end
  end

  always @(negedge clk) begin
    int at;
    if (rstn && rvalid2) begin
      if (q2.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_pulse2: got rvalid at cycle %0d expected none", cyc);
      end else begin
        at = q2.pop_front();
        chk("hold_cycle", 64'(cyc), 64'(at));
        chk("hold_rdata", rdata2, 64'hDEAD_BEEF_CAFE_F00D);
        chk("hold_wready", 64'(wready2), 64'd0);
      end
    end
  end

  task automatic preload(input bit second, input logic [3:0] idx, input logic [63:0] v);
    @(negedge clk);
    pl_idx = idx; pl_val = v;
    if (second) pl2_en = 1'b1; else pl1_en = 1'b1;
    @(negedge clk);
    pl1_en = 1'b0; pl2_en = 1'b0;
  endtask

  task automatic txn(input bit wr, input bit rd, input logic [31:0] a,
                     input logic [63:0] wd, input logic [1:0] wl,
                     input bit mis_e, input logic [63:0] exp_rd);
    exp_t e;
    int   t, off, n;
    bit   done;
    @(negedge clk);
    t = cyc;
    d_addr = a; rd_en = rd; wr_en = wr; wdata = wd; wlen = wl;
    if (!wr) begin
      off = 2 + LAT; hold_rd = exp_rd;
    end else if (mis_e)   off = 1;
    else if (wl == 2'd3)  off = 2;
    else                  off = 3 + LAT;
    e.wr = wr; e.mis = mis_e; e.rd = hold_rd; e.at = t + off;
    q1.push_back(e);
    @(negedge clk);
    chk("ce_T1", 64'(m_ce), 64'(!(wr && mis_e)));
    chk("we_T1", 64'(m_we), 64'(wr && !mis_e && wl == 2'd3));
    chk("addr_T1", 64'(m_addr), (wr && mis_e) ? 64'd0 : 64'(a[31:3]));
    done = wready || rvalid;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      done = wready || rvalid;
      n++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL timeout: got no completion expected one by cycle %0d", t + off);
    end
    rd_en = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int t, ce0, we0, n;
    repeat (3) @(negedge clk);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_mis", 64'(mis), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_ce", 64'(m_ce), 64'd0);
    chk("rst_we", 64'(m_we), 64'd0);
    chk("rst_maddr", 64'(m_addr), 64'd0);
    chk("rst_mwdata", m_wdata, 64'd0);
    rstn = 1'b1;

    // plain read
    preload(1'b0, 4'd2, 64'hDEAD_BEEF_CAFE_F00D);
    txn(1'b0, 1'b1, 32'h14, 64'd0, 2'd0, 1'b0, 64'hDEAD_BEEF_CAFE_F00D);

    // reset arriving during the RMW read must abandon the store
    preload(1'b0, 4'd2, 64'h1122_3344_5566_7788);
    @(negedge clk);
    we0 = we_cnt;
    d_addr = 32'h10; wr_en = 1'b1; wlen = 2'd0; wdata = 64'hAB;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0; wr_en = 1'b0;
    #1;
    chk("rstmid_ce", 64'(m_ce), 64'd0);
    chk("rstmid_we", 64'(m_we), 64'd0);
    chk("rstmid_rdata", rdata, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    hold_rd = '0;
    @(negedge clk);
    chk("rstmid_no_write", 64'(we_cnt - we0), 64'd0);
    chk("rstmid_mem_kept", mem1[2], 64'h1122_3344_5566_7788);
    txn(1'b0, 1'b1, 32'h10, 64'd0, 2'd0, 1'b0, 64'h1122_3344_5566_7788);

    // byte RMW
    txn(1'b1, 1'b0, 32'h13, 64'hAB, 2'd0, 1'b0, 64'd0);
    chk("byte_rmw_mem", mem1[2], 64'h1122_3344_AB66_7788);

    // dword with simultaneous read request: write wins
    txn(1'b1, 1'b1, 32'h8, 64'h0123_4567_89AB_CDEF, 2'd3, 1'b0, 64'd0);
    chk("dword_mem", mem1[1], 64'h0123_4567_89AB_CDEF);

    // misaligned stores: no SRAM traffic, memory unchanged
    ce0 = ce_cnt;
    txn(1'b1, 1'b0, 32'h6, 64'hFFFF_FFFF, 2'd2, 1'b1, 64'd0);
    txn(1'b1, 1'b0, 32'h11, 64'hFFFF, 2'd1, 1'b1, 64'd0);
    txn(1'b1, 1'b0, 32'hC, 64'hFFFF, 2'd3, 1'b1, 64'd0);
    chk("mis_no_ce", 64'(ce_cnt - ce0), 64'd0);
    chk("mis_mem_kept", mem1[2], 64'h1122_3344_AB66_7788);

    // half and word RMW into the same doubleword, then read back
    preload(1'b0, 4'd3, 64'hAAAA_BBBB_CCCC_DDDD);
    txn(1'b1, 1'b0, 32'h1A, 64'hFFFF_1234, 2'd1, 1'b0, 64'd0);
    chk("half_rmw_mem", mem1[3], 64'hAAAA_BBBB_1234_DDDD);
    txn(1'b1, 1'b0, 32'h1C, 64'h9999_8888_7777_6666, 2'd2, 1'b0, 64'd0);
    chk("word_rmw_mem", mem1[3], 64'h7777_6666_1234_DDDD);
    txn(1'b0, 1'b1, 32'h18, 64'd0, 2'd0, 1'b0, 64'h7777_6666_1234_DDDD);

    // read request held high on the long-latency instance
    preload(1'b1, 4'd2, 64'hDEAD_BEEF_CAFE_F00D);
    @(negedge clk);
    t = cyc;
    d_addr2 = 32'h14; rd_en2 = 1'b1;
    for (int k = 0; k < 3; k++) q2.push_back(t + LAT2 + 2 + k * (LAT2 + 4));
    n = 0;
    while (q2.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    rd_en2 = 1'b0;
    repeat (12) @(negedge clk);

    chk("sb1_drained", 64'(q1.size()), 64'd0);
    chk("sb2_drained", 64'(q2.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before time 200000");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory controller directly downstream of the two-port data arbiter.
- Consumes the arbiter's single memory-side request group (addr, rdata_en, wdata_en, wdata, wlen) and returns wdata_ready, rdata and rdata_valid.
- Drives a word-wide (64-bit) synchronous SRAM that has no byte-write mask. Sub-word stores are therefore done as read-modify-write (RMW).
- Adds fixed, deterministic multi-cycle latency and flags misaligned stores.

Parameters:
ADDR_W, 32, width of data_addr_in (`DATA_ADDR_BUS)
MEM_LAT, 1, cycles from SRAM read issue (mem_ce=1, mem_we=0) to valid mem_rdata; legal range 1..7

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
data_addr_in  input  ADDR_W  byte address from arbiter
rdata_en_in  input  1  read request, active-high, level-held
wdata_en_in  input  1  write request, active-high, level-held
wdata_in  input  64  store data, LSB-aligned
wlen_in  input  2  store size: 0=byte, 1=half, 2=word, 3=dword
wdata_ready_out  output  1  one-cycle write-complete pulse
rdata_out  output  64  aligned doubleword containing the address; held until the next read completes
rdata_valid_out  output  1  one-cycle read-complete pulse
misalign_err_out  output  1  one-cycle pulse, coincident with wdata_ready_out, for a rejected store
mem_ce  output  1  SRAM access enable
mem_we  output  1  SRAM write enable (qualified by mem_ce)
mem_addr  output  ADDR_W-3  SRAM doubleword index, equal to latched addr[ADDR_W-1:3]
mem_wdata  output  64  SRAM write data
mem_rdata  input  64  SRAM read data

Behaviour:
- Reset: async on rstn low. State returns to IDLE. Every output is 0, including rdata_out and mem_*. A write in flight is abandoned: mem_we/mem_ce are state-decoded, so they drop immediately and the SRAM is never written after reset asserts.
- All outputs are registered or decoded from the state register only. No combinational path exists from any *_in input to any output.
- States: IDLE, RD_ISSUE, RD_WAIT, RMW_ISSUE, RMW_WAIT, WR_ISSUE, RESP, HOLD.
- IDLE, request sampling:
  - wdata_en_in=1 has priority over rdata_en_in; both high is treated as a write.
  - On accept, latch addr, wdata, wlen and the op type. Input changes after accept are ignored.
- Write misalignment: half with addr[0]≠0, word with addr[1:0]≠0, dword with addr[2:0]≠0.
  - A misaligned store goes straight to RESP.
  - In RESP it raises wdata_ready_out=1 and misalign_err_out=1 with no SRAM access.
- Read path (accept at cycle T, with LAT = MEM_LAT):
  - T+1: RD_ISSUE drives mem_ce=1, mem_we=0.
  - RD_WAIT counts LAT cycles and captures mem_rdata into rdata_out at T+1+LAT.
  - T+2+LAT: RESP, rdata_valid_out=1.
  - Reads are never checked for alignment.
- Dword write: T+1 WR_ISSUE drives mem_ce=1, mem_we=1, mem_wdata=wdata. T+2 RESP, wdata_ready_out=1.
- Sub-word write (RMW):
  - T+1: RMW_ISSUE reads the target doubleword.
  - RMW_WAIT captures mem_rdata after LAT cycles and merges the store into it.
  - Lane offset is addr[2:0]×8 bits. Byte replaces 8 bits, half 16, word 32; all other bits are preserved.
  - T+2+LAT: WR_ISSUE writes the merged word.
  - T+3+LAT: RESP, wdata_ready_out=1.
- RESP lasts exactly one cycle, then HOLD for one cycle. In HOLD, request inputs are ignored.
- Upstream contract: the requester deasserts its enable in the cycle after the completion pulse. IDLE can accept at RESP+2.
- Throughput: at most one transaction per (latency+2) cycles.
- rdata_out is unchanged by writes and by misaligned stores.
- mem_addr and mem_wdata are 0 whenever mem_ce=0.

Test Plan:
- Reset mid-RMW: byte store to 0x10, rstn pulled low during RMW_WAIT -> mem_we never asserted; after release, reading 0x10 returns the pre-existing 0x1122334455667788.
- Read, MEM_LAT=1: SRAM word 0x2 preloaded 0xDEADBEEFCAFEF00D; rdata_en_in=1, addr=0x14 at T -> mem_ce at T+1; rdata_valid_out=1 for one cycle at T+3 with rdata_out=0xDEADBEEFCAFEF00D.
- Byte RMW: word 0x2 = 0x1122334455667788; write wlen=0, addr=0x13, wdata=0xAB -> SRAM becomes 0x11223344AB667788; wdata_ready_out pulses at T+4 (MEM_LAT=1).
- Dword and priority: rdata_en_in=1 and wdata_en_in=1 together, wlen=3, addr=0x8, wdata=0x0123456789ABCDEF -> write performed; wdata_ready_out at T+2; rdata_valid_out stays 0.
- Misaligned: wlen=2, addr=0x6 -> mem_ce stays 0; wdata_ready_out=1 and misalign_err_out=1 at T+1.
- Hold-off: keep rdata_en_in high through HOLD -> exactly one rdata_valid_out pulse per (MEM_LAT+4) cycles; MEM_LAT=3 gives read completion at T+5.
